excp_commit_ctrl: RTL and testbench



---
 rtl/excp_commit_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_excp_commit_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/excp_commit_ctrl.sv
// -----------------------------------------------------------------------------
// excp_commit_ctrl
//   Commit-stage exception sequencer between writeback and the CSR file.
//   Picks one event (interrupt > sync exception > ERTN) at the committing
//   instruction, waits for outstanding bus transactions to drain, strobes the
//   CSR file for one cycle, then flushes the pipe and redirects fetch.
//
//   Build option:
//     EXCP_CTRL_INT_EN  defined  : has_int is taken at commit (ecode 0x00)
//                       undefined: has_int is ignored
//
//   Ports:
//     clk, resetn                      clock, async active-low reset
//     wb_*                             committing instruction and its flags
//     wb_ready / wb_commit             commit accepted / normal retire
//     has_int, eentry, era             from the CSR file
//     bus_req_issue / bus_resp_done    outstanding-transaction tracking
//     bus_block                        forbid new bus issue
//     excp_flush, ertn_flush, ecode,
//     esubcode, epc, eaddr             CSR file update strobe and payload
//     pipe_flush, redirect_valid,
//     redirect_pc                      pipeline kill and fetch redirect
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | accepting commits, watching for an event
//   DRAIN    | event captured, waiting for outstanding bus traffic to end
//   FLUSH    | one-cycle CSR strobe plus pipe_flush
//   REDIRECT | fetch redirect to eentry/era, CSR file already updated
// -----------------------------------------------------------------------------
module excp_commit_ctrl #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic        wb_excp,
  input  logic [5:0]  wb_ecode,
  input  logic [2:0]  wb_esubcode,
  input  logic [31:0] wb_badaddr,
  input  logic        wb_ertn,
  output logic        wb_ready,
  output logic        wb_commit,
  input  logic        has_int,
  input  logic [31:0] eentry,
  input  logic [31:0] era,
  input  logic        bus_req_issue,
  input  logic        bus_resp_done,
  output logic        bus_block,
  output logic        excp_flush,
  output logic        ertn_flush,
  output logic [5:0]  ecode,
  output logic [2:0]  esubcode,
  output logic [31:0] epc,
  output logic [31:0] eaddr,
  output logic        pipe_flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FLUSH, S_REDIRECT} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_ertn_q;
  logic [5:0]       ecode_q;
  logic [2:0]       esubcode_q;
  logic [31:0]      epc_q, eaddr_q;
  logic             wb_ready_q, excp_flush_q, ertn_flush_q, pipe_flush_q, redirect_valid_q;

  logic int_take, ev, ev_ertn;

`ifdef EXCP_CTRL_INT_EN
  assign int_take = has_int;
`else
  // has_int is read but masked so the port stays connected in this build
  assign int_take = has_int & 1'b0;
`endif

  assign ev      = (state_q == S_IDLE) & wb_valid & (int_take | wb_excp | wb_ertn);
  assign ev_ertn = ~int_take & ~wb_excp;

  // Saturating up/down count; issue is counted regardless of bus_block
  always_comb begin
    cnt_d = cnt_q;
    if (bus_req_issue && !bus_resp_done && cnt_q != CNT_MAX)
      cnt_d = cnt_q + CNT_W'(1);
    else if (!bus_req_issue && bus_resp_done && cnt_q != '0)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q          <= S_IDLE;
      is_ertn_q        <= 1'b0;
      ecode_q          <= '0;
      esubcode_q       <= '0;
      epc_q            <= '0;
      eaddr_q          <= '0;
      wb_ready_q       <= 1'b1;
      excp_flush_q     <= 1'b0;
      ertn_flush_q     <= 1'b0;
      pipe_flush_q     <= 1'b0;
      redirect_valid_q <= 1'b0;
    end else begin
      excp_flush_q     <= 1'b0;
      ertn_flush_q     <= 1'b0;
      pipe_flush_q     <= 1'b0;
      redirect_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ev) begin
            epc_q      <= wb_pc;
            is_ertn_q  <= ev_ertn;
            wb_ready_q <= 1'b0;
            if (int_take) begin
              ecode_q    <= '0;
              esubcode_q <= '0;
              eaddr_q    <= '0;
            end else if (wb_excp) begin
              ecode_q    <= wb_ecode;
              esubcode_q <= wb_esubcode;
              eaddr_q    <= wb_badaddr;
            end
            // a same-cycle issue at count 0 still has to drain first
            if (cnt_q == '0 && cnt_d == '0) begin
              state_q      <= S_FLUSH;
              excp_flush_q <= ~ev_ertn;
              ertn_flush_q <= ev_ertn;
              pipe_flush_q <= 1'b1;
            end else begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (cnt_d == '0) begin
            state_q      <= S_FLUSH;
            excp_flush_q <= ~is_ertn_q;
            ertn_flush_q <= is_ertn_q;
            pipe_flush_q <= 1'b1;
          end
        end
        S_FLUSH: begin
          state_q          <= S_REDIRECT;
          redirect_valid_q <= 1'b1;
        end
        S_REDIRECT: begin
          state_q    <= S_IDLE;
          wb_ready_q <= 1'b1;
        end
        default: begin
          state_q    <= S_IDLE;
          wb_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign wb_ready       = wb_ready_q;
  assign wb_commit      = wb_valid & wb_ready_q & ~ev;
  assign bus_block      = (state_q != S_IDLE) | ev;
  assign excp_flush     = excp_flush_q;
  assign ertn_flush     = ertn_flush_q;
  assign pipe_flush     = pipe_flush_q;
  assign redirect_valid = redirect_valid_q;
  // eentry/era read live: the CSR file has absorbed the strobe by now
  assign redirect_pc    = redirect_valid_q ? (is_ertn_q ? era : eentry) : 32'h0;
  assign ecode          = ecode_q;
  assign esubcode       = esubcode_q;
  assign epc            = epc_q;
  assign eaddr          = eaddr_q;

endmodule

// File: tb/tb_excp_commit_ctrl.sv
module tb_excp_commit_ctrl;
  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb_valid, wb_excp, wb_ertn, has_int, bus_req_issue, bus_resp_done;
  logic [31:0] wb_pc, wb_badaddr, eentry, era;
  logic [5:0]  wb_ecode;
  logic [2:0]  wb_esubcode;
  logic        wb_ready, wb_commit, bus_block, excp_flush, ertn_flush, pipe_flush, redirect_valid;
  logic [5:0]  ecode;
  logic [2:0]  esubcode;
  logic [31:0] epc, eaddr, redirect_pc;

  excp_commit_ctrl #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .resetn(resetn),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_excp(wb_excp), .wb_ecode(wb_ecode),
    .wb_esubcode(wb_esubcode), .wb_badaddr(wb_badaddr), .wb_ertn(wb_ertn),
    .wb_ready(wb_ready), .wb_commit(wb_commit), .has_int(has_int),
    .eentry(eentry), .era(era), .bus_req_issue(bus_req_issue),
    .bus_resp_done(bus_resp_done), .bus_block(bus_block),
    .excp_flush(excp_flush), .ertn_flush(ertn_flush), .ecode(ecode),
    .esubcode(esubcode), .epc(epc), .eaddr(eaddr), .pipe_flush(pipe_flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // reference model: outstanding count plus a timeline of the pending event
  bit          m_busy, m_ertn;
  int          m_flush_at, m_cnt;
  logic [5:0]  m_ec;
  logic [2:0]  m_esc;
  logic [31:0] m_epc, m_eaddr;

  typedef struct {
    logic        valid, excp, ertn, hint;
    logic [5:0]  ec;
    logic [2:0]  esc;
    logic [31:0] bad, pc, ent, er;
    logic        x_ev, x_excp;
    logic [5:0]  x_ec;
    logic [2:0]  x_esc;
    logic [31:0] x_epc, x_eaddr, x_rpc;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit int_on();
`ifdef EXCP_CTRL_INT_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_busy = 0; m_ertn = 0; m_flush_at = -1; m_cnt = 0;
    m_ec = '0; m_esc = '0; m_epc = '0; m_eaddr = '0;
  endtask

  task automatic clear_in();
    wb_valid = 0; wb_excp = 0; wb_ertn = 0; has_int = 0;
    bus_req_issue = 0; bus_resp_done = 0;
    wb_pc = '0; wb_badaddr = '0; wb_ecode = '0; wb_esubcode = '0;
  endtask

  // Called just after a falling edge with inputs applied: checks every
  // output against the model, then advances model and DUT by one clock.
  task automatic tick();
    bit evm, fl, rd, it;
    int nc;
    #1;
    it  = int_on() && has_int;
    evm = !m_busy && wb_valid && (it || wb_excp || wb_ertn);
    fl  = m_busy && (cyc == m_flush_at);
    rd  = m_busy && (m_flush_at >= 0) && (cyc == m_flush_at + 1);
    chk1("m_wb_ready", wb_ready, !m_busy);
    chk1("m_wb_commit", wb_commit, !m_busy && wb_valid && !evm);
    chk1("m_bus_block", bus_block, m_busy || evm);
    chk1("m_excp_flush", excp_flush, fl && !m_ertn);
    chk1("m_ertn_flush", ertn_flush, fl && m_ertn);
    chk1("m_pipe_flush", pipe_flush, fl);
    chk1("m_redirect_valid", redirect_valid, rd);
    chk("m_redirect_pc", redirect_pc, rd ? (m_ertn ? era : eentry) : 32'h0);
    chk("m_ecode", 32'(ecode), 32'(m_ec));
    chk("m_esubcode", 32'(esubcode), 32'(m_esc));
    chk("m_epc", epc, m_epc);
    chk("m_eaddr", eaddr, m_eaddr);
    chk("m_cnt", 32'(dut.cnt_q), 32'(m_cnt));
    nc = m_cnt + int'(bus_req_issue) - int'(bus_resp_done);
    if (nc > MAXO) nc = MAXO;
    if (nc < 0) nc = 0;
    @(posedge clk);
    if (evm) begin
      m_epc  = wb_pc;
      m_ertn = !(it || wb_excp);
      if (it) begin
        m_ec = '0; m_esc = '0; m_eaddr = '0;
      end else if (wb_excp) begin
        m_ec = wb_ecode; m_esc = wb_esubcode; m_eaddr = wb_badaddr;
      end
      m_busy     = 1;
      m_flush_at = (m_cnt == 0 && nc == 0) ? cyc + 1 : -1;
    end else if (m_busy) begin
      if (m_flush_at < 0) begin
        if (nc == 0) m_flush_at = cyc + 1;
      end else if (cyc == m_flush_at + 1) begin
        m_busy = 0;
        m_flush_at = -1;
      end
    end
    m_cnt = nc;
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    clear_in();
    eentry = '0; era = '0;
    resetn = 1'b0;
    model_reset();

    tbl[0] = '{1'b1,1'b1,1'b0,1'b0, 6'h09,3'd0, 32'h1003, 32'h1c000100, 32'h1c008000, 32'h0,
               1'b1,1'b1, 6'h09,3'd0, 32'h1c000100, 32'h1003, 32'h1c008000};
    tbl[1] = '{1'b1,1'b0,1'b1,1'b0, 6'h3f,3'd7, 32'hffff, 32'h1c000300, 32'h1c008000, 32'h1c000204,
               1'b1,1'b0, 6'h09,3'd0, 32'h1c000300, 32'h1003, 32'h1c000204};
    tbl[2] = '{1'b1,1'b0,1'b0,1'b0, 6'h11,3'd2, 32'h55, 32'h1c000310, 32'h1c008000, 32'h1c000204,
               1'b0,1'b0, 6'h09,3'd0, 32'h1c000300, 32'h1003, 32'h0};
    tbl[3] = '{1'b0,1'b1,1'b0,1'b0, 6'h12,3'd1, 32'h66, 32'h1c000320, 32'h1c008000, 32'h1c000204,
               1'b0,1'b0, 6'h09,3'd0, 32'h1c000300, 32'h1003, 32'h0};
`ifdef EXCP_CTRL_INT_EN
    tbl[4] = '{1'b1,1'b1,1'b1,1'b1, 6'h0d,3'd3, 32'hdead0000, 32'h1c000400, 32'h1c00a000, 32'h1c000500,
               1'b1,1'b1, 6'h00,3'd0, 32'h1c000400, 32'h0, 32'h1c00a000};
    tbl[5] = '{1'b1,1'b0,1'b0,1'b1, 6'h22,3'd5, 32'h77, 32'h1c000410, 32'h1c00b000, 32'h1c000500,
               1'b1,1'b1, 6'h00,3'd0, 32'h1c000410, 32'h0, 32'h1c00b000};
`else
    tbl[4] = '{1'b1,1'b1,1'b1,1'b1, 6'h0d,3'd3, 32'hdead0000, 32'h1c000400, 32'h1c00a000, 32'h1c000500,
               1'b1,1'b1, 6'h0d,3'd3, 32'h1c000400, 32'hdead0000, 32'h1c00a000};
    tbl[5] = '{1'b1,1'b0,1'b0,1'b1, 6'h22,3'd5, 32'h77, 32'h1c000410, 32'h1c00b000, 32'h1c000500,
               1'b0,1'b0, 6'h0d,3'd3, 32'h1c000400, 32'hdead0000, 32'h0};
`endif
    tbl[6] = '{1'b1,1'b1,1'b1,1'b0, 6'h21,3'd1, 32'h44, 32'h1c000600, 32'h1c00c000, 32'h1c000700,
               1'b1,1'b1, 6'h21,3'd1, 32'h1c000600, 32'h44, 32'h1c00c000};

    // reset values
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_wb_ready", wb_ready, 1'b1);
    chk1("rst_wb_commit", wb_commit, 1'b0);
    chk1("rst_bus_block", bus_block, 1'b0);
    chk1("rst_excp_flush", excp_flush, 1'b0);
    chk1("rst_ertn_flush", ertn_flush, 1'b0);
    chk1("rst_pipe_flush", pipe_flush, 1'b0);
    chk1("rst_redirect_valid", redirect_valid, 1'b0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    chk("rst_ecode", 32'(ecode), 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_eaddr", eaddr, 32'h0);
    chk("rst_cnt", 32'(dut.cnt_q), 32'h0);
    resetn = 1'b1;
    @(negedge clk);

    // table-driven single events, bus idle
    for (int i = 0; i < 7; i++) begin
      wb_valid = tbl[i].valid; wb_excp = tbl[i].excp; wb_ertn = tbl[i].ertn;
      has_int = tbl[i].hint; wb_ecode = tbl[i].ec; wb_esubcode = tbl[i].esc;
      wb_badaddr = tbl[i].bad; wb_pc = tbl[i].pc; eentry = tbl[i].ent; era = tbl[i].er;
      #1;
      chk1("tbl_wb_commit", wb_commit, tbl[i].valid & ~tbl[i].x_ev);
      chk1("tbl_bus_block", bus_block, tbl[i].x_ev);
      chk1("tbl_wb_ready", wb_ready, 1'b1);
      tick();
      wb_valid = 0; wb_excp = 0; wb_ertn = 0; has_int = 0;
      #1;
      chk1("tbl_excp_flush", excp_flush, tbl[i].x_ev & tbl[i].x_excp);
      chk1("tbl_ertn_flush", ertn_flush, tbl[i].x_ev & ~tbl[i].x_excp);
      chk1("tbl_pipe_flush", pipe_flush, tbl[i].x_ev);
      chk("tbl_ecode", 32'(ecode), 32'(tbl[i].x_ec));
      chk("tbl_esubcode", 32'(esubcode), 32'(tbl[i].x_esc));
      chk("tbl_epc", epc, tbl[i].x_epc);
      chk("tbl_eaddr", eaddr, tbl[i].x_eaddr);
      tick();
      if (tbl[i].x_ev) begin
        #1;
        chk1("tbl_redirect_valid", redirect_valid, 1'b1);
        chk("tbl_redirect_pc", redirect_pc, tbl[i].x_rpc);
        chk1("tbl_redir_no_flush", pipe_flush | excp_flush | ertn_flush, 1'b0);
        tick();
        #1;
        chk1("tbl_ready_back", wb_ready, 1'b1);
      end
    end

    // drain: 3 issues, event, 3 dones two cycles apart
    bus_req_issue = 1;
    repeat (3) tick();
    bus_req_issue = 0;
    wb_valid = 1; wb_excp = 1; wb_ecode = 6'h05; wb_pc = 32'h1c000800; wb_badaddr = 32'h88;
    eentry = 32'h1c00d000;
    #1;
    chk1("drain_ev_block", bus_block, 1'b1);
    tick();
    clear_in();
    for (int i = 0; i < 5; i++) begin
      bus_resp_done = (i % 2 == 0);
      #1;
      chk1("drain_hold_flush", excp_flush, 1'b0);
      chk1("drain_bus_block", bus_block, 1'b1);
      chk1("drain_wb_ready", wb_ready, 1'b0);
      tick();
    end
    bus_resp_done = 0;
    #1;
    chk1("drain_flush_strobe", excp_flush, 1'b1);
    repeat (3) tick();

    // counter edges
    bus_req_issue = 1;
    repeat (2) tick();
    bus_resp_done = 1;
    tick();
    bus_resp_done = 0;
    #1;
    chk("cnt_simul", 32'(dut.cnt_q), 32'd2);
    repeat (2) tick();
    #1;
    chk("cnt_full", 32'(dut.cnt_q), 32'd4);
    tick();
    #1;
    chk("cnt_sat", 32'(dut.cnt_q), 32'd4);
    bus_req_issue = 0; bus_resp_done = 1;
    repeat (4) tick();
    #1;
    chk("cnt_empty", 32'(dut.cnt_q), 32'd0);
    tick();
    #1;
    chk("cnt_no_wrap", 32'(dut.cnt_q), 32'd0);
    bus_resp_done = 0;
    tick();

    // reset in the middle of DRAIN
    bus_req_issue = 1;
    tick();
    bus_req_issue = 0;
    wb_valid = 1; wb_excp = 1; wb_ecode = 6'h07; wb_pc = 32'h1c000900;
    tick();
    clear_in();
    tick();
    resetn = 1'b0;
    model_reset();
    #1;
    chk1("mrst_wb_ready", wb_ready, 1'b1);
    chk1("mrst_bus_block", bus_block, 1'b0);
    chk1("mrst_pipe_flush", pipe_flush, 1'b0);
    chk1("mrst_excp_flush", excp_flush, 1'b0);
    chk("mrst_cnt", 32'(dut.cnt_q), 32'h0);
    chk("mrst_epc", epc, 32'h0);
    chk("mrst_ecode", 32'(ecode), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk1("mrst_no_strobe", excp_flush | ertn_flush | pipe_flush, 1'b0);
      tick();
    end

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      wb_valid      = ($urandom % 4) != 0;
      wb_excp       = ($urandom % 8) == 0;
      wb_ertn       = ($urandom % 10) == 0;
      has_int       = ($urandom % 12) == 0;
      wb_ecode      = 6'($urandom);
      wb_esubcode   = 3'($urandom);
      wb_badaddr    = $urandom;
      wb_pc         = $urandom;
      eentry        = $urandom;
      era           = $urandom;
      bus_req_issue = ($urandom % 3) == 0;
      bus_resp_done = ($urandom % 3) == 0;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
